// File: rtl/prng_seq_ctrl.sv
// Sequencer for the shift/xor/and/add PRNG datapath: loads seed and count, then steps A once per output word.
// Optional stall watchdog in RUN is built only when PRNG_CTRL_WDOG_EN is defined.
//
// state  | meaning
// IDLE   | waiting for start; all strobes low
// LOAD_A | seed_in onto the bus, load A
// LOAD_B | count_in onto the bus, load B
// CHECK  | eq now reflects the loaded count; zero count skips RUN
// RUN    | one word per fire (A<=nseed, B--, out_data<=z) under valid/ready
// DONE   | wait for last word to drain, then pulse done
module prng_seq_ctrl #(
  parameter int WIDTH       = 16,
  parameter int CNT_W       = 16,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] seed_in,
  input  logic [CNT_W-1:0] count_in,
  input  logic             eq,
  input  logic [WIDTH-1:0] z,
  input  logic             out_ready,
  output logic             lda,
  output logic             ldb,
  output logic             decb,
  output logic [1:0]       bus_sel,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_CHECK,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_nxt;
  logic   fire;
  logic   wdog_trip;

  // Host seed/count travel on the datapath bus; the controller only sequences them.
  logic unused_ok;
  assign unused_ok = ^{seed_in, count_in, (WDOG_CYCLES > 0)};

  assign fire = (state == S_RUN) && !eq && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_LOAD_A;
      S_LOAD_A: state_nxt = S_LOAD_B;
      S_LOAD_B: state_nxt = S_CHECK;
      S_CHECK:  state_nxt = eq ? S_DONE : S_RUN;
      S_RUN: begin
        if (eq)             state_nxt = S_DONE;
        else if (wdog_trip) state_nxt = S_IDLE;
      end
      S_DONE:   if (!out_valid) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    lda     = 1'b0;
    ldb     = 1'b0;
    decb    = 1'b0;
    bus_sel = 2'b00;
    case (state)
      S_LOAD_A: lda = 1'b1;
      S_LOAD_B: begin
        ldb     = 1'b1;
        bus_sel = 2'b01;
      end
      S_RUN: begin
        if (fire) begin
          lda     = 1'b1;
          decb    = 1'b1;
          bus_sel = 2'b10;
        end
      end
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);

  // A held word is never overwritten: fire already requires the slot to be free or consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= (state == S_DONE) && !out_valid;
      if (fire) begin
        out_data  <= z;
        out_valid <= 1'b1;
      end else if (wdog_trip || out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef PRNG_CTRL_WDOG_EN
  localparam int WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

  logic [WDOG_W-1:0] wdog_cnt;
  logic              stall;

  assign stall     = (state == S_RUN) && !eq && !fire;
  assign wdog_trip = stall && (wdog_cnt == '0);

  // Down-counter reloads on any non-stall cycle; terminal count on a stall cycle aborts the run.
  always_ff @(posedge clk) begin
    if (rst || !stall || wdog_trip) wdog_cnt <= WDOG_W'(WDOG_CYCLES - 1);
    else                            wdog_cnt <= wdog_cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)                          err <= 1'b0;
    else if (state == S_IDLE && start) err <= 1'b0;
    else if (wdog_trip)                err <= 1'b1;
  end
`else
  assign wdog_trip = 1'b0;
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_prng_seq_ctrl.sv
// Bench for prng_seq_ctrl: behavioural datapath plus a word-sequence model checked every cycle.
module tb_prng_seq_ctrl;

`ifdef PRNG_CTRL_WDOG_EN
  localparam int WDOG = 16;
`else
  localparam int WDOG = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] seed_in = '0;
  logic [15:0] count_in = '0;
  logic        eq;
  logic [15:0] z;
  logic        out_ready = 1'b1;
  logic        lda, ldb, decb, out_valid, busy, done, err;
  logic [1:0]  bus_sel;
  logic [15:0] out_data;

  prng_seq_ctrl #(.WIDTH(16), .CNT_W(16), .WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .rst(rst), .start(start), .seed_in(seed_in), .count_in(count_in),
    .eq(eq), .z(z), .out_ready(out_ready), .lda(lda), .ldb(ldb), .decb(decb),
    .bus_sel(bus_sel), .out_data(out_data), .out_valid(out_valid), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] prng_next(input logic [15:0] a);
    return {a[14:0], 1'b0} ^ (a >> 3) ^ (a & 16'h00F0);
  endfunction

  // Datapath: A seed register, B down-counter, eqz and sum output.
  logic [15:0] dp_a, dp_b, bus;
  always_comb begin
    case (bus_sel)
      2'b00:   bus = seed_in;
      2'b01:   bus = count_in;
      2'b10:   bus = prng_next(dp_a);
      default: bus = 16'h0000;
    endcase
  end
  assign eq = (dp_b == 16'h0000);
  assign z  = prng_next(dp_a) + dp_a;

  always @(posedge clk) begin
    if (rst) begin
      dp_a <= '0;
      dp_b <= '0;
    end else begin
      if (lda) dp_a <= bus;
      if (ldb)       dp_b <= bus;
      else if (decb) dp_b <= dp_b - 16'd1;
    end
  end

  int cmp_cnt = 0;
  int mis_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [15:0] exp_q[$];
  logic [15:0] got_words[$];
  int lda_cnt, ldb_cnt, decb_cnt, done_cnt, word_cnt;
  bit valid_seen;
  bit prev_hold = 1'b0;
  logic [15:0] prev_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_word", {16'h0, out_data}, 32'hDEAD_0000);
        end else begin
          chk("word", {16'h0, out_data}, {16'h0, exp_q[0]});
          void'(exp_q.pop_front());
        end
        got_words.push_back(out_data);
        word_cnt++;
      end
      if (prev_hold && out_valid) chk("hold_data", {16'h0, out_data}, {16'h0, prev_data});
      if (decb) chk("fire_strobes", {29'h0, lda, bus_sel}, 32'h6);
      if (out_valid && !out_ready) chk("no_overwrite", {31'h0, decb}, 32'h0);
`ifndef PRNG_CTRL_WDOG_EN
      chk("err_const", {31'h0, err}, 32'h0);
`endif
      lda_cnt  += int'(lda);
      ldb_cnt  += int'(ldb);
      decb_cnt += int'(decb);
      done_cnt += int'(done);
      if (out_valid) valid_seen = 1'b1;
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  // n counts samples after the edge that accepted start (n=1 is right after that edge).
  task automatic run_seq(input logic [15:0] seed, input logic [15:0] cnt, input int stall_len,
                         input int poke_n, input int rst_words, output int n_done,
                         output int n_first, output int n_errf, output logic err_at1);
    logic [15:0] a;
    int n, stall_rem, rst_n;
    bit stalling, did_rst;
    exp_q.delete();
    got_words.delete();
    a = seed;
    for (int i = 0; i < int'(cnt); i++) begin
      exp_q.push_back(prng_next(a) + a);
      a = prng_next(a);
    end
    lda_cnt = 0; ldb_cnt = 0; decb_cnt = 0; done_cnt = 0; word_cnt = 0; valid_seen = 1'b0;
    n = 0; n_done = -1; n_first = -1; n_errf = -1; err_at1 = 1'b0;
    stall_rem = stall_len; stalling = (stall_len != 0); did_rst = 1'b0; rst_n = -1;
    @(posedge clk); #1;
    seed_in = seed; count_in = cnt; start = 1'b1; out_ready = !stalling;
    while (n < 400) begin
      @(posedge clk); #1;
      start = (poke_n > 0 && n == poke_n);
      rst = 1'b0;
      if (stalling && n_first > 0 && stall_len > 0) begin
        if (stall_rem == 0) begin
          chk("stall_decb", decb_cnt, 1);
          out_ready = 1'b1;
          stalling = 1'b0;
        end else stall_rem--;
      end
      if (rst_words > 0 && !did_rst && word_cnt >= rst_words) begin
        rst = 1'b1; did_rst = 1'b1; rst_n = n + 2;
      end
      @(negedge clk);
      n++;
      if (n == 1) err_at1 = err;
      if (out_valid && n_first < 0) n_first = n;
      if (err && n_errf < 0) n_errf = n;
      if (n == rst_n) begin
        chk("rst_valid", {31'h0, out_valid}, 0);
        chk("rst_busy", {31'h0, busy}, 0);
      end
      if (done) begin
        n_done = n;
        break;
      end
      if (did_rst && n >= rst_n + 8) break;
      if (n_errf >= 0 && n >= n_errf + 4) break;
    end
    start = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("after_busy", {31'h0, busy}, 0);
    chk("after_done", {31'h0, done}, 0);
  endtask

  int nd, nf, ne;
  logic e1;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_strobes", {24'h0, lda, ldb, decb, bus_sel, out_valid, busy, done}, 0);
    chk("reset_data", {16'h0, out_data}, 0);
    chk("reset_err", {31'h0, err}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: seed 0x1234, three words, first valid five cycles after start was driven
    run_seq(16'h1234, 16'd3, 0, 0, 0, nd, nf, ne, e1);
    chk("t1_done_seen", {31'h0, nd > 0}, 1);
    chk("t1_first_valid", nf, 5);
    chk("t1_words", word_cnt, 3);
    chk("t1_word0", {16'h0, (got_words.size() > 0) ? got_words[0] : 16'h0}, 32'h3852);
    chk("t1_word1", {16'h0, (got_words.size() > 1) ? got_words[1] : 16'h0}, 32'h6F0D);
    chk("t1_lda", lda_cnt, 4);
    chk("t1_ldb", ldb_cnt, 1);
    chk("t1_decb", decb_cnt, 3);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_q_empty", exp_q.size(), 0);

    // 2: zero count, no words, done at the fifth sample
    run_seq(16'hBEEF, 16'd0, 0, 0, 0, nd, nf, ne, e1);
    chk("t2_done_at", nd, 5);
    chk("t2_no_valid", {31'h0, valid_seen}, 0);
    chk("t2_lda", lda_cnt, 1);
    chk("t2_decb", decb_cnt, 0);
    chk("t2_done_cnt", done_cnt, 1);

    // 3: consumer stalls after the first word
    run_seq(16'hACE1, 16'd4, 10, 0, 0, nd, nf, ne, e1);
    chk("t3_done_seen", {31'h0, nd > 0}, 1);
    chk("t3_words", word_cnt, 4);
    chk("t3_decb", decb_cnt, 4);
    chk("t3_done_cnt", done_cnt, 1);
    chk("t3_q_empty", exp_q.size(), 0);

    // 4: start pulsed during RUN is ignored
    run_seq(16'h0F0F, 16'd5, 0, 7, 0, nd, nf, ne, e1);
    chk("t4_words", word_cnt, 5);
    chk("t4_ldb", ldb_cnt, 1);
    chk("t4_done_cnt", done_cnt, 1);

    // 5: reset two words into an eight-word run, then a clean run
    run_seq(16'h5A5A, 16'd8, 0, 0, 2, nd, nf, ne, e1);
    chk("t5_no_done", nd, -1);
    chk("t5_done_cnt", done_cnt, 0);
    run_seq(16'h1357, 16'd2, 0, 0, 0, nd, nf, ne, e1);
    chk("t5b_words", word_cnt, 2);
    chk("t5b_done_cnt", done_cnt, 1);
    chk("t5b_q_empty", exp_q.size(), 0);

`ifdef PRNG_CTRL_WDOG_EN
    // 6: consumer never ready; first word at 5, then 16 stall cycles trip the watchdog
    run_seq(16'h2222, 16'd3, -1, 0, 0, nd, nf, ne, e1);
    chk("t6_err_at", ne, 21);
    chk("t6_no_done", nd, -1);
    chk("t6_done_cnt", done_cnt, 0);
    chk("t6_err_held", {31'h0, err}, 1);
    chk("t6_valid_clr", {31'h0, out_valid}, 0);
    out_ready = 1'b1;
    run_seq(16'h3333, 16'd1, 0, 0, 0, nd, nf, ne, e1);
    chk("t6_err_cleared", {31'h0, e1}, 0);
    chk("t6b_words", word_cnt, 1);
    chk("t6b_done_cnt", done_cnt, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
